// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM request sequencer slice.
// Contents:
//   - Address field widths and bit positions of the linear word address
//     {bank[25:24], row[23:12], col[11:0]}.
//   - Sequencer FSM state encoding.
//   - Request FIFO entry layout {we, addr, wdata} (43 bits).
package sdram_pkg;

    localparam int BANK_W   = 2;
    localparam int ROW_W    = 12;
    localparam int COL_W    = 12;
    localparam int ADDR_W   = 26;
    localparam int DATA_W   = 16;

    localparam int COL_LSB  = 0;
    localparam int ROW_LSB  = 12;
    localparam int BANK_LSB = 24;

    localparam int ENTRY_W  = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_entry_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous request FIFO for the SDRAM sequencer.
// Ports:
//   SDRAM_CLK_IN  clock
//   reset         synchronous active-high reset, empties the FIFO
//   push / din    write an entry (ignored when full)
//   pop  / dout   consume the head entry (ignored when empty); dout shows the head
//   full, empty   status derived from the registered count
//   count         number of stored entries (log2(DEPTH)+1 bits)
module sdram_req_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 4
) (
    input  logic                     SDRAM_CLK_IN,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // DEPTH is a power of two, so the count reaches DEPTH exactly when its MSB sets.
    assign full  = count[PTR_W];
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage array: written on an accepted push, never reset since the
    // count alone decides which entries are meaningful.
    always_ff @(posedge SDRAM_CLK_IN) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; a simultaneous push and pop leaves
    // the count unchanged.
    always_ff @(posedge SDRAM_CLK_IN) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_req_sequencer.sv
// Front-end for the IS42S16160B SDRAM driver: queues user requests and
// issues them one at a time as active-low start strobes, watching the
// driver's process_flg to detect acceptance and completion.
// Ports:
//   SDRAM_CLK_IN, reset            clock (shared with driver), sync active-high reset
//   req_valid/req_ready            request handshake into the FIFO
//   req_we, req_addr, req_wdata    request op, {bank,row,col} address, write data
//   proc_flg                       driver busy indication
//   start_write, start_read        active-low one-cycle strobes to the driver
//   ADDR_ROW, ADDR_COL, BANK       address of the active request
//   cur_wdata                      write data of the active request (0 for reads)
//   done, done_we                  completion pulse and its op
//   err_timeout                    sticky abandon flag
//   done_cnt                       wrapping completed-request count
module sdram_req_sequencer
    import sdram_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int ACK_TIMEOUT  = 64,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic              SDRAM_CLK_IN,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              proc_flg,
    output logic              start_write,
    output logic              start_read,
    output logic [ROW_W-1:0]  ADDR_ROW,
    output logic [COL_W-1:0]  ADDR_COL,
    output logic [BANK_W-1:0] BANK,
    output logic [DATA_W-1:0] cur_wdata,
    output logic              done,
    output logic              done_we,
    output logic              err_timeout,
    output logic [15:0]       done_cnt
);

    localparam int TMR_W = $clog2((DONE_TIMEOUT > ACK_TIMEOUT) ? DONE_TIMEOUT : ACK_TIMEOUT);
    localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] DONE_LAST = TMR_W'(DONE_TIMEOUT - 1);

    seq_state_e               state, next_state;
    logic [TMR_W-1:0]         timer, next_timer;
    logic                     cur_we, next_we;
    logic [ROW_W-1:0]         next_row;
    logic [COL_W-1:0]         next_col;
    logic [BANK_W-1:0]        next_bank;
    logic [DATA_W-1:0]        next_wdata;
    logic                     next_start_write, next_start_read;
    logic                     next_done, next_done_we, next_err;
    logic [15:0]              next_cnt;

    req_entry_t               fifo_din, fifo_dout;
    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                     unused_fifo_level;

    assign req_ready         = !fifo_full;
    assign fifo_push         = req_valid && req_ready;
    assign fifo_din          = {req_we, req_addr, req_wdata};
    assign unused_fifo_level = ^fifo_count;

    sdram_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .SDRAM_CLK_IN (SDRAM_CLK_IN),
        .reset        (reset),
        .push         (fifo_push),
        .pop          (fifo_pop),
        .din          (fifo_din),
        .dout         (fifo_dout),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count)
    );

    // Register stage: every output is registered so the strobe lands one
    // cycle after the address registers load, giving the driver a full
    // cycle of stable address before it sees the strobe.
    always_ff @(posedge SDRAM_CLK_IN) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            cur_we      <= 1'b0;
            ADDR_ROW    <= '0;
            ADDR_COL    <= '0;
            BANK        <= '0;
            cur_wdata   <= '0;
            start_write <= 1'b1;
            start_read  <= 1'b1;
            done        <= 1'b0;
            done_we     <= 1'b0;
            err_timeout <= 1'b0;
            done_cnt    <= '0;
        end else begin
            state       <= next_state;
            timer       <= next_timer;
            cur_we      <= next_we;
            ADDR_ROW    <= next_row;
            ADDR_COL    <= next_col;
            BANK        <= next_bank;
            cur_wdata   <= next_wdata;
            start_write <= next_start_write;
            start_read  <= next_start_read;
            done        <= next_done;
            done_we     <= next_done_we;
            err_timeout <= next_err;
            done_cnt    <= next_cnt;
        end
    end

    // Next-state logic. A request is popped only while the driver is idle,
    // then exactly one strobe is issued and the FSM waits for process_flg
    // to rise (accept) and fall (complete), abandoning on either timeout.
    always_comb begin
        next_state       = state;
        next_timer       = timer;
        next_we          = cur_we;
        next_row         = ADDR_ROW;
        next_col         = ADDR_COL;
        next_bank        = BANK;
        next_wdata       = cur_wdata;
        next_start_write = 1'b1;
        next_start_read  = 1'b1;
        next_done        = 1'b0;
        next_done_we     = done_we;
        next_err         = err_timeout;
        next_cnt         = done_cnt;
        fifo_pop         = 1'b0;

        case (state)
            S_IDLE: begin
                if (!fifo_empty && !proc_flg) begin
                    fifo_pop   = 1'b1;
                    next_we    = fifo_dout.we;
                    next_row   = fifo_dout.addr[ROW_LSB +: ROW_W];
                    next_col   = fifo_dout.addr[COL_LSB +: COL_W];
                    next_bank  = fifo_dout.addr[BANK_LSB +: BANK_W];
                    next_wdata = fifo_dout.we ? fifo_dout.wdata : '0;
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                next_start_write = !cur_we;
                next_start_read  = cur_we;
                next_timer       = '0;
                next_state       = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (proc_flg) begin
                    next_timer = '0;
                    next_state = S_WAIT_DONE;
                end else if (timer == ACK_LAST) begin
                    next_err   = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_timer = timer + TMR_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!proc_flg) begin
                    next_done    = 1'b1;
                    next_done_we = cur_we;
                    next_cnt     = done_cnt + 16'd1;
                    next_state   = S_IDLE;
                end else if (timer == DONE_LAST) begin
                    next_err   = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_timer = timer + TMR_W'(1);
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_req_sequencer.sv
// Directed bench for sdram_req_sequencer with a simple driver model that
// raises proc_flg for busyLen cycles after each strobe.
module tb_sdram_req_sequencer;
    import sdram_pkg::*;

    logic        SDRAM_CLK_IN = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [25:0] req_addr;
    logic [15:0] req_wdata;
    logic        proc_flg;
    logic        start_write, start_read;
    logic [11:0] ADDR_ROW, ADDR_COL;
    logic [1:0]  BANK;
    logic [15:0] cur_wdata;
    logic        done, done_we, err_timeout;
    logic [15:0] done_cnt;

    sdram_req_sequencer dut (
        .SDRAM_CLK_IN (SDRAM_CLK_IN),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .proc_flg     (proc_flg),
        .start_write  (start_write),
        .start_read   (start_read),
        .ADDR_ROW     (ADDR_ROW),
        .ADDR_COL     (ADDR_COL),
        .BANK         (BANK),
        .cur_wdata    (cur_wdata),
        .done         (done),
        .done_we      (done_we),
        .err_timeout  (err_timeout),
        .done_cnt     (done_cnt)
    );

    always #5 SDRAM_CLK_IN = ~SDRAM_CLK_IN;

    // Driver model: busy for busyLen cycles after a strobe when responding,
    // plus a manual busy term for init/refresh scenarios.
    logic manualBusy = 1'b0;
    logic respond    = 1'b0;
    int   busyLen    = 12;
    int   busyCnt    = 0;
    assign proc_flg = manualBusy | (busyCnt != 0);

    always @(posedge SDRAM_CLK_IN) begin
        if (respond && (!start_write || !start_read)) busyCnt <= busyLen;
        else if (busyCnt != 0) busyCnt <= busyCnt - 1;
    end

    // Strobe/done monitor
    int   overlapCnt = 0, maxLow = 0, lowRun = 0, strobeCnt = 0;
    logic [26:0] strobeLog[$];
    logic        doneWeLog[$];

    always @(negedge SDRAM_CLK_IN) begin
        if (!start_write && !start_read) overlapCnt++;
        if (!start_write || !start_read) begin
            lowRun++;
            if (lowRun > maxLow) maxLow = lowRun;
            if (lowRun == 1) begin
                strobeCnt++;
                strobeLog.push_back({!start_write, BANK, ADDR_ROW, ADDR_COL});
            end
        end else begin
            lowRun = 0;
        end
        if (done) doneWeLog.push_back(done_we);
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge SDRAM_CLK_IN);
    endtask

    task automatic doReset();
        reset = 1'b1;
        req_valid = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    // Present one request from a negedge; accepted when ready is seen high.
    task automatic applyStimulus(input logic we, input logic [25:0] addr, input logic [15:0] wd,
                                 input int maxWait, output bit accepted);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        accepted  = 1'b0;
        for (int i = 0; i < maxWait && !accepted; i++) begin
            if (req_ready) accepted = 1'b1;
            @(negedge SDRAM_CLK_IN);
        end
        req_valid = 1'b0;
    endtask

    task automatic waitStrobe(input int maxCycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge SDRAM_CLK_IN);
            if (!start_write || !start_read) seen = 1'b1;
        end
    endtask

    task automatic waitDone(input int maxCycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge SDRAM_CLK_IN);
            if (done) seen = 1'b1;
        end
    endtask

    logic [25:0] addrTab [6];
    logic [5:0]  weTab;

    initial begin
        bit acc, seen, early;
        int accCnt, strobeBase;
        logic [25:0] rAddr;
        logic        rWe;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge SDRAM_CLK_IN);
        reset = 1'b0;
        tick(1);

        // Reset values
        checkOutput("rst_start_write", start_write, 1);
        checkOutput("rst_start_read",  start_read,  1);
        checkOutput("rst_row",         ADDR_ROW,    0);
        checkOutput("rst_col",         ADDR_COL,    0);
        checkOutput("rst_bank",        BANK,        0);
        checkOutput("rst_wdata",       cur_wdata,   0);
        checkOutput("rst_done",        done,        0);
        checkOutput("rst_err",         err_timeout, 0);
        checkOutput("rst_cnt",         done_cnt,    0);
        checkOutput("rst_ready",       req_ready,   1);

        // Test 1: driver busy holds off the strobe, then one write completes
        manualBusy = 1'b1;
        applyStimulus(1'b1, 26'h1ABC123, 16'hBEEF, 5, acc);
        checkOutput("t1_accept", acc, 1);
        tick(200);
        checkOutput("t1_no_strobe_busy", strobeCnt, 0);
        checkOutput("t1_not_popped_row", ADDR_ROW, 0);
        respond = 1'b1; busyLen = 12; manualBusy = 1'b0;
        waitStrobe(20, seen);
        checkOutput("t1_strobe_seen", seen, 1);
        checkOutput("t1_wr_low",  start_write, 0);
        checkOutput("t1_rd_high", start_read, 1);
        checkOutput("t1_bank", BANK, 1);
        checkOutput("t1_row", ADDR_ROW, 12'hABC);
        checkOutput("t1_col", ADDR_COL, 12'h123);
        checkOutput("t1_wdata", cur_wdata, 16'hBEEF);
        tick(1);
        checkOutput("t1_wr_one_cycle", start_write, 1);
        waitDone(40, seen);
        checkOutput("t1_done_seen", seen, 1);
        checkOutput("t1_done_we", done_we, 1);
        checkOutput("t1_done_cnt", done_cnt, 1);
        checkOutput("t1_err", err_timeout, 0);
        tick(1);
        checkOutput("t1_done_pulse", done, 0);

        // Test 2: FIFO fills at 4, then drains in order
        doReset();
        addrTab[0] = 26'h0111222; addrTab[1] = 26'h1333444; addrTab[2] = 26'h2555666;
        addrTab[3] = 26'h3777888; addrTab[4] = 26'h0999AAA; addrTab[5] = 26'h1BBBCCC;
        weTab = 6'b101101;
        manualBusy = 1'b1; respond = 1'b1; busyLen = 5;
        accCnt = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(weTab[i], addrTab[i], 16'h1000 + 16'(i), 1, acc);
            if (acc) accCnt++;
        end
        checkOutput("t2_accepted", accCnt, 4);
        checkOutput("t2_ready_low", req_ready, 0);
        strobeLog.delete(); doneWeLog.delete();
        manualBusy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            waitDone(100, seen);
            checkOutput("t2_done_seen", seen, 1);
        end
        tick(5);
        checkOutput("t2_done_cnt", done_cnt, 4);
        checkOutput("t2_strobe_n", strobeLog.size(), 4);
        checkOutput("t2_done_n", doneWeLog.size(), 4);
        for (int i = 0; i < 4 && i < strobeLog.size() && i < doneWeLog.size(); i++) begin
            checkOutput("t2_order", strobeLog[i], {weTab[i], addrTab[i]});
            checkOutput("t2_done_we", doneWeLog[i], weTab[i]);
        end

        // Test 3: unacknowledged read times out after 64 cycles
        doReset();
        respond = 1'b0; manualBusy = 1'b1;
        applyStimulus(1'b0, 26'h2345678, 16'hDEAD, 5, acc);
        applyStimulus(1'b1, 26'h000F0F0, 16'h55AA, 5, acc);
        manualBusy = 1'b0;
        waitStrobe(20, seen);
        checkOutput("t3_strobe_seen", seen, 1);
        checkOutput("t3_rd_low", start_read, 0);
        checkOutput("t3_wr_high", start_write, 1);
        checkOutput("t3_bank", BANK, 2);
        checkOutput("t3_row", ADDR_ROW, 12'h345);
        checkOutput("t3_col", ADDR_COL, 12'h678);
        checkOutput("t3_rd_wdata_zero", cur_wdata, 0);
        tick(63);
        checkOutput("t3_err_early", err_timeout, 0);
        tick(1);
        checkOutput("t3_err_set", err_timeout, 1);
        checkOutput("t3_no_done_cnt", done_cnt, 0);
        respond = 1'b1; busyLen = 6;
        waitStrobe(10, seen);
        checkOutput("t3_next_strobe", seen, 1);
        checkOutput("t3_next_wr", start_write, 0);
        checkOutput("t3_next_row", ADDR_ROW, 12'h00F);
        checkOutput("t3_next_col", ADDR_COL, 12'h0F0);
        checkOutput("t3_next_wdata", cur_wdata, 16'h55AA);
        waitDone(50, seen);
        checkOutput("t3_next_done", seen, 1);
        checkOutput("t3_next_cnt", done_cnt, 1);
        checkOutput("t3_err_sticky", err_timeout, 1);

        // Test 4: driver stays busy past DONE_TIMEOUT
        doReset();
        respond = 1'b0; manualBusy = 1'b0;
        applyStimulus(1'b1, 26'h3FFFFFF, 16'hFFFF, 5, acc);
        waitStrobe(20, seen);
        checkOutput("t4_strobe_seen", seen, 1);
        checkOutput("t4_bank", BANK, 3);
        checkOutput("t4_row", ADDR_ROW, 12'hFFF);
        manualBusy = 1'b1;
        tick(1024);
        checkOutput("t4_err_early", err_timeout, 0);
        tick(1);
        checkOutput("t4_err_set", err_timeout, 1);
        checkOutput("t4_state_idle", 32'(dut.state), 32'(S_IDLE));
        tick(1500 - 1025);
        manualBusy = 1'b0;
        tick(5);
        checkOutput("t4_no_done", done_cnt, 0);

        // Test 5: reset in S_WAIT_DONE with 3 requests queued
        doReset();
        respond = 1'b1; busyLen = 40; manualBusy = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 26'h0100000 + 26'(i), 16'hA000 + 16'(i), 5, acc);
        manualBusy = 1'b0;
        waitStrobe(10, seen);
        checkOutput("t5_strobe_seen", seen, 1);
        tick(5);
        checkOutput("t5_in_wait_done", 32'(dut.state), 32'(S_WAIT_DONE));
        reset = 1'b1;
        tick(1);
        checkOutput("t5_start_write", start_write, 1);
        checkOutput("t5_start_read", start_read, 1);
        checkOutput("t5_row", ADDR_ROW, 0);
        checkOutput("t5_col", ADDR_COL, 0);
        checkOutput("t5_wdata", cur_wdata, 0);
        checkOutput("t5_done_we", done_we, 0);
        checkOutput("t5_ready", req_ready, 1);
        checkOutput("t5_fifo_empty", dut.u_fifo.empty, 1);
        reset = 1'b0;
        strobeBase = strobeCnt;
        tick(100);
        checkOutput("t5_no_strobe", strobeCnt, strobeBase);
        checkOutput("t5_cnt", done_cnt, 0);

        // Test 6: refresh pulse extends S_WAIT_DONE, then 20 random requests
        respond = 1'b1; busyLen = 10;
        applyStimulus(1'b1, 26'h05552AA, 16'h1234, 5, acc);
        waitStrobe(20, seen);
        checkOutput("t6_strobe_seen", seen, 1);
        tick(4);
        manualBusy = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge SDRAM_CLK_IN);
            if (done) early = 1'b1;
        end
        checkOutput("t6_no_early_done", early, 0);
        manualBusy = 1'b0;
        tick(1);
        checkOutput("t6_done", done, 1);
        checkOutput("t6_err", err_timeout, 0);
        checkOutput("t6_cnt", done_cnt, 1);
        for (int i = 0; i < 20; i++) begin
            rWe = 1'($urandom_range(0, 1));
            rAddr = 26'($urandom);
            busyLen = int'($urandom_range(1, 8));
            applyStimulus(rWe, rAddr, 16'($urandom), 200, acc);
            if (!acc) checkOutput("t6_rand_accept", acc, 1);
            waitDone(200, seen);
            if (!seen) checkOutput("t6_rand_done", seen, 1);
        end
        tick(5);
        checkOutput("t6_rand_cnt", done_cnt, 21);
        checkOutput("t6_no_overlap", overlapCnt, 0);
        checkOutput("t6_strobe_width", maxLow, 1);
        checkOutput("t6_rand_err", err_timeout, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
